// File: rtl/ltp_pkg.sv
// Shared constants for the L/T/P input conditioner: code width, bit positions
// within CODE, and the default debounce length.
package ltp_pkg;

   localparam int unsigned CODE_W           = 3;
   localparam int unsigned L_IDX            = 2;
   localparam int unsigned T_IDX            = 1;
   localparam int unsigned P_IDX            = 0;
   localparam int unsigned DEFAULT_DEBOUNCE = 4;

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input: two-flop synchronizer, saturating debounce counter and
// registered output with a one-cycle toggle flag.
module debounce_bit
   import ltp_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic EN,
   input  logic RAW,
   output logic OUT,
   output logic TOGGLE,
   output logic BUSY
);

   localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            out_q, out_d;
   logic            toggle_q, toggle_d;

   always_comb begin
      sync1_d  = RAW;
      sync2_d  = sync1_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      toggle_d = 1'b0;
      // With EN low only the synchronizers advance; everything else holds.
      if (EN) begin
         if (sync2_q == out_q) begin
            cnt_d = '0;
         end else if (cnt_q == CntMax) begin
            out_d    = sync2_q;
            cnt_d    = '0;
            toggle_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CntOne;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         out_q    <= 1'b0;
         toggle_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         toggle_q <= toggle_d;
      end
   end

   assign OUT    = out_q;
   assign TOGGLE = toggle_q;
   assign BUSY   = (cnt_q != '0) || (sync2_q != out_q);

endmodule

// File: rtl/ltp_input_conditioner.sv
// Debounces the L/T/P sensor levels for the G/Y/D/C/R decode stage and reports
// change and stability status.
module ltp_input_conditioner
   import ltp_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              L_RAW,
   input  logic              T_RAW,
   input  logic              P_RAW,
   input  logic              EN,
   output logic              L,
   output logic              T,
   output logic              P,
   output logic [CODE_W-1:0] CODE,
   output logic              CHG,
   output logic              STABLE
);

   logic [CODE_W-1:0] raw_vec;
   logic [CODE_W-1:0] out_vec;
   logic [CODE_W-1:0] toggle_vec;
   logic [CODE_W-1:0] busy_vec;
   logic              stable_q, stable_d;

   assign raw_vec[L_IDX] = L_RAW;
   assign raw_vec[T_IDX] = T_RAW;
   assign raw_vec[P_IDX] = P_RAW;

   for (genvar i = 0; i < CODE_W; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce_bit (
         .CLK   (CLK),
         .RST_N (RST_N),
         .EN    (EN),
         .RAW   (raw_vec[i]),
         .OUT   (out_vec[i]),
         .TOGGLE(toggle_vec[i]),
         .BUSY  (busy_vec[i])
      );
   end

   always_comb begin
      stable_d = ~|busy_vec;
   end

   // Reset leaves every input settled, so STABLE comes out of reset high.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         stable_q <= 1'b1;
      end else begin
         stable_q <= stable_d;
      end
   end

   assign L      = out_vec[L_IDX];
   assign T      = out_vec[T_IDX];
   assign P      = out_vec[P_IDX];
   assign CODE   = out_vec;
   assign CHG    = |toggle_vec;
   assign STABLE = stable_q;

endmodule

// File: tb/tb_ltp_input_conditioner.sv
// Directed bench for ltp_input_conditioner: stimulus queues expected CHG events,
// an independent monitor matches every CHG pulse against that queue.
module tb_ltp_input_conditioner;

   localparam int D = 4;

   typedef struct {
      int         cyc;
      logic [2:0] code;
   } exp_t;

   logic       CLK;
   logic       RST_N;
   logic       L_RAW, T_RAW, P_RAW;
   logic       EN;
   logic       L, T, P;
   logic [2:0] CODE;
   logic       CHG;
   logic       STABLE;

   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_err  = 0;
   bit   mon_en = 1'b0;
   bit   done   = 1'b0;
   exp_t exp_q[$];

   ltp_input_conditioner #(
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .L_RAW (L_RAW),
      .T_RAW (T_RAW),
      .P_RAW (P_RAW),
      .EN    (EN),
      .L     (L),
      .T     (T),
      .P     (P),
      .CODE  (CODE),
      .CHG   (CHG),
      .STABLE(STABLE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Expect a CHG pulse with the given CODE 'lat' edges after the current one.
   task automatic push(input int lat, input logic [2:0] code);
      exp_t e;
      e.cyc  = cyc + lat;
      e.code = code;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: cycle %0d got %b, required %b", name, cyc, act, req);
      end
   endtask

   // Monitor: every CHG pulse must match the head of the queue, in cycle and code.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (mon_en && !done) begin
            if (CHG === 1'b1) begin
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL chg_unexpected: cycle %0d CODE=%b, required no CHG", cyc, CODE);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || CODE !== e.code || {L, T, P} !== e.code) begin
                     n_err++;
                     $display("FAIL chg_event: cycle %0d CODE=%b LTP=%b, required cycle %0d CODE=%b",
                              cyc, CODE, {L, T, P}, e.cyc, e.code);
                  end
               end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
               e = exp_q.pop_front();
               n_vec++;
               n_err++;
               $display("FAIL chg_missing: cycle %0d CHG=%b CODE=%b, required CHG=1 CODE=%b at %0d",
                        cyc, CHG, CODE, e.code, e.cyc);
            end
         end
      end
   end

   initial begin
      L_RAW = 1'b1;
      T_RAW = 1'b1;
      P_RAW = 1'b1;
      EN    = 1'b1;
      RST_N = 1'b0;

      // Reset with all raw inputs high.
      tick(2);
      check("rst_code", CODE, 3'b000);
      check("rst_chg", {2'b00, CHG}, 3'b000);
      check("rst_stable", {2'b00, STABLE}, 3'b001);
      mon_en = 1'b1;
      RST_N  = 1'b1;
      push(D + 2, 3'b111);
      tick(10);
      check("rel_code", CODE, 3'b111);
      check("rel_stable", {2'b00, STABLE}, 3'b001);

      {L_RAW, T_RAW, P_RAW} = 3'b000;
      push(D + 2, 3'b000);
      tick(10);

      // Latency on L.
      L_RAW = 1'b1;
      push(D + 2, 3'b100);
      tick(D + 1);
      check("lat_early", CODE, 3'b000);
      tick(9);
      L_RAW = 1'b0;
      push(D + 2, 3'b000);
      tick(10);

      // T glitch of 3 sampled cycles is rejected.
      T_RAW = 1'b1;
      tick(3);
      T_RAW = 1'b0;
      tick(1);
      check("glitch_busy", {2'b00, STABLE}, 3'b000);
      tick(10);
      check("glitch_stable", {2'b00, STABLE}, 3'b001);
      check("glitch_t", {2'b00, T}, 3'b000);

      // T pulse of 4 sampled cycles is accepted, then returns to 0.
      T_RAW = 1'b1;
      push(D + 2, 3'b010);
      push(D + 6, 3'b000);
      tick(4);
      T_RAW = 1'b0;
      tick(12);

      // Enable freeze of 5 cycles midway through a P change.
      P_RAW = 1'b1;
      push(D + 2 + 5, 3'b001);
      tick(3);
      EN = 1'b0;
      tick(5);
      EN = 1'b1;
      tick(10);
      check("freeze_p", {2'b00, P}, 3'b001);
      P_RAW = 1'b0;
      push(D + 2, 3'b000);
      tick(10);

      // Simultaneous L and P change.
      L_RAW = 1'b1;
      P_RAW = 1'b1;
      push(D + 2, 3'b101);
      tick(10);
      L_RAW = 1'b0;
      P_RAW = 1'b0;
      push(D + 2, 3'b000);
      tick(10);

      // Reset for one cycle at count 2 of a T change; debounce restarts in full.
      T_RAW = 1'b1;
      tick(4);
      RST_N = 1'b0;
      push(D + 3, 3'b010);
      tick(1);
      RST_N = 1'b1;
      check("midrst_t", {2'b00, T}, 3'b000);
      check("midrst_stable", {2'b00, STABLE}, 3'b001);
      tick(D + 1);
      check("midrst_late", {2'b00, T}, 3'b000);
      tick(10);
      T_RAW = 1'b0;
      push(D + 2, 3'b000);
      tick(12);

      done = 1'b1;
      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL chg_pending: CHG with CODE=%b expected at cycle %0d never seen",
                  e.code, e.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
